// File: rtl/wb_simple_master.sv
// Wishbone classic single-transfer master.
// Turns one command from a valid/ready port into one Wishbone read or write cycle.
// The result comes back on a valid/ready response port. A watchdog aborts the cycle
// with rsp_err_o when the slave never acks.
//
// Ports:
//   wb_clk_i, rst_n_i         clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake; cmd_we_i/addr/data/sel carry the payload
//   rsp_valid_o/rsp_ready_i   response handshake; rsp_data_o read data, rsp_err_o timeout flag
//   wb_cyc_o..wb_sel_o        Wishbone master outputs
//   wb_data_i, wb_ack_i       Wishbone slave returns
module wb_simple_master #(
   parameter int unsigned g_addr_width = 32,
   parameter int unsigned g_data_width = 32,
   parameter int unsigned g_timeout    = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        rst_n_i,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic                        cmd_we_i,
   input  logic [g_addr_width-1:0]     cmd_addr_i,
   input  logic [g_data_width-1:0]     cmd_data_i,
   input  logic [g_data_width/8-1:0]   cmd_sel_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [g_data_width-1:0]     rsp_data_o,
   output logic                        rsp_err_o,
   output logic                        wb_cyc_o,
   output logic                        wb_stb_o,
   output logic                        wb_we_o,
   output logic [g_addr_width-1:0]     wb_addr_o,
   output logic [g_data_width-1:0]     wb_data_o,
   output logic [g_data_width/8-1:0]   wb_sel_o,
   input  logic [g_data_width-1:0]     wb_data_i,
   input  logic                        wb_ack_i
);

   // The counter only has to reach g_timeout-1, so it never wraps.
   localparam int unsigned CntW = (g_timeout > 1) ? $clog2(g_timeout + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (g_timeout != 0) ? CntW'(g_timeout - 1) : '0;

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e                      state_q;
   logic [CntW-1:0]             cnt_q;
   logic                        we_q;
   logic [g_addr_width-1:0]     addr_q;
   logic [g_data_width-1:0]     data_q;
   logic [g_data_width/8-1:0]   sel_q;
   logic [g_data_width-1:0]     rsp_data_q;
   logic                        rsp_err_q;

   always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         sel_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid_i) begin
                  // Write data is latched for reads too; slaves ignore it.
                  we_q    <= cmd_we_i;
                  addr_q  <= cmd_addr_i;
                  data_q  <= cmd_data_i;
                  sel_q   <= cmd_sel_i;
                  cnt_q   <= '0;
                  state_q <= StBus;
               end
            end
            StBus: begin
               // Ack takes priority over a timeout on the same edge.
               if (wb_ack_i) begin
                  rsp_data_q <= we_q ? '0 : wb_data_i;
                  rsp_err_q  <= 1'b0;
                  state_q    <= StResp;
               end else if ((g_timeout != 0) && (cnt_q == CntLast)) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= StResp;
               end else if (g_timeout != 0) begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake and bus strobes decode straight from the state register, so the async reset
   // drops cyc/stb immediately.
   assign cmd_ready_o = (state_q == StIdle);
   assign rsp_valid_o = (state_q == StResp);
   assign wb_cyc_o    = (state_q == StBus);
   assign wb_stb_o    = (state_q == StBus);
   assign wb_we_o     = we_q;
   assign wb_addr_o   = addr_q;
   assign wb_data_o   = data_q;
   assign wb_sel_o    = sel_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_simple_master.sv
// Self-checking bench for wb_simple_master.
// It uses a behavioural slave with a programmable ack delay and a reference memory model.
module tb_wb_simple_master;

   localparam int Timeout = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_data;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [31:0] wb_addr, wb_wdata, wb_rdata;
   logic [3:0]  wb_sel;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_simple_master #(
      .g_addr_width(32),
      .g_data_width(32),
      .g_timeout   (Timeout)
   ) dut (
      .wb_clk_i   (clk),
      .rst_n_i    (rst_n),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_we_i   (cmd_we),
      .cmd_addr_i (cmd_addr),
      .cmd_data_i (cmd_data),
      .cmd_sel_i  (cmd_sel),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_data_o (rsp_data),
      .rsp_err_o  (rsp_err),
      .wb_cyc_o   (wb_cyc),
      .wb_stb_o   (wb_stb),
      .wb_we_o    (wb_we),
      .wb_addr_o  (wb_addr),
      .wb_data_o  (wb_wdata),
      .wb_sel_o   (wb_sel),
      .wb_data_i  (wb_rdata),
      .wb_ack_i   (wb_ack)
   );

   // Behavioural slave: acks combinationally once cyc has been high for slv_delay cycles.
   logic [31:0] slv_mem [16];
   int          slv_wait  = 0;
   int          slv_delay = 0;
   bit          slv_en    = 1'b1;
   bit          force_ack = 1'b0;
   bit          mem_clr   = 1'b0;

   assign wb_ack   = force_ack | (wb_cyc & wb_stb & slv_en & (slv_wait >= slv_delay));
   assign wb_rdata = slv_mem[wb_addr[3:0]];

   always @(posedge clk) begin
      if (wb_cyc) slv_wait <= slv_wait + 1;
      else        slv_wait <= 0;
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
      end else if (wb_cyc && wb_stb && wb_ack && wb_we) begin
         for (int b = 0; b < 4; b++)
            if (wb_sel[b]) slv_mem[wb_addr[3:0]][8*b +: 8] <= wb_wdata[8*b +: 8];
      end
   end

   // Reference memory model.
   logic [31:0] ref_mem [16];

   // One full transfer. mode: 0 plain, 1 poke cmd_valid while stalled, 2 spurious ack while stalled.
   task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input int delay, input bit en, input int hold,
                         input int mode, input string name);
      int          idx, exp_cycles, cycles, guard;
      bit          acked, exp_err, bus_bad, stall_bad;
      logic [31:0] exp_data;
      idx        = int'(addr[3:0]);
      acked      = en && (delay < Timeout);
      exp_cycles = acked ? delay + 1 : Timeout;
      exp_err    = !acked;
      exp_data   = (acked && !we) ? ref_mem[idx] : 32'h0;
      if (acked && we)
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];

      slv_delay = delay;
      slv_en    = en;
      @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s cmd_ready before cmd: got %b want 1", name, cmd_ready);
      end
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_sel = sel;
      @(negedge clk);
      // Scramble the command inputs so the bus side must hold its latched copy.
      cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = $urandom; cmd_data = $urandom; cmd_sel = ~sel;
      cycles = 0; guard = 0; bus_bad = 1'b0;
      while (rsp_valid !== 1'b1 && guard < 100) begin
         if (wb_cyc === 1'b1) begin
            cycles++;
            if (wb_stb !== 1'b1 || wb_we !== we || wb_addr !== addr || wb_wdata !== data ||
                wb_sel !== sel || cmd_ready !== 1'b0) bus_bad = 1'b1;
         end
         @(negedge clk);
         guard++;
      end
      n_tests++;
      if (guard >= 100) begin
         n_fail++;
         $display("FAIL %s rsp wait: no rsp_valid within 100 cycles", name);
      end
      n_tests++;
      if (bus_bad) begin
         n_fail++;
         $display("FAIL %s bus fields: cyc phase got unstable/wrong we/addr/data/sel/stb", name);
      end
      n_tests++;
      if (cycles !== exp_cycles) begin
         n_fail++;
         $display("FAIL %s cyc length: got %0d want %0d", name, cycles, exp_cycles);
      end
      n_tests++;
      if (rsp_err !== exp_err || rsp_data !== exp_data || wb_cyc !== 1'b0) begin
         n_fail++;
         $display("FAIL %s response: got err=%b data=%h cyc=%b want err=%b data=%h cyc=0",
                  name, rsp_err, rsp_data, wb_cyc, exp_err, exp_data);
      end
      stall_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (mode == 1) cmd_valid = 1'b1;
         if (mode == 2) force_ack = 1'b1;
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err ||
             cmd_ready !== 1'b0 || wb_cyc !== 1'b0) stall_bad = 1'b1;
      end
      cmd_valid = 1'b0;
      force_ack = 1'b0;
      if (hold > 0) begin
         n_tests++;
         if (stall_bad) begin
            n_fail++;
            $display("FAIL %s stall: response changed or cmd accepted while rsp_ready=0", name);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_tests++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc !== 1'b0) begin
         n_fail++;
         $display("FAIL %s release: got rsp_valid=%b cmd_ready=%b cyc=%b want 0/1/0",
                  name, rsp_valid, cmd_ready, wb_cyc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_clr = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset handshake: got ready=%b rvalid=%b err=%b data=%h want 1/0/0/0",
                  cmd_ready, rsp_valid, rsp_err, rsp_data);
      end
      n_tests++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0 || wb_addr !== 32'h0 ||
          wb_wdata !== 32'h0 || wb_sel !== 4'h0) begin
         n_fail++;
         $display("FAIL reset bus: got cyc=%b stb=%b we=%b addr=%h data=%h sel=%h want all 0",
                  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel);
      end
      rst_n = 1'b1; mem_clr = 1'b0;
   endtask

   task automatic test_write_read();
      do_cmd(1'b1, 32'h0, 32'hffff0000, 4'hf, 0, 1'b1, 0, 0, "write_ddr");
      do_cmd(1'b0, 32'h0, 32'h12345678, 4'hf, 0, 1'b1, 0, 0, "readback_ddr");
   endtask

   task automatic test_backpressure();
      do_cmd(1'b1, 32'h4, 32'hdeadbeef, 4'hf, 1, 1'b1, 0, 0, "bp_write");
      do_cmd(1'b0, 32'h4, 32'h0, 4'hf, 0, 1'b1, 5, 1, "bp_read");
   endtask

   task automatic test_timeout();
      do_cmd(1'b0, 32'h2, 32'h0, 4'hf, 0, 1'b0, 2, 0, "timeout_noack");
      do_cmd(1'b1, 32'h2, 32'h5a5a5a5a, 4'hf, Timeout - 1, 1'b1, 0, 0, "ack_on_last");
      do_cmd(1'b0, 32'h2, 32'h0, 4'hf, Timeout - 1, 1'b1, 0, 0, "read_on_last");
   endtask

   task automatic test_spurious_ack();
      @(negedge clk);
      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      force_ack = 1'b0;
      n_tests++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_cyc !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious idle: got ready=%b rvalid=%b cyc=%b want 1/0/0",
                  cmd_ready, rsp_valid, wb_cyc);
      end
      do_cmd(1'b0, 32'h0, 32'h0, 4'hf, 2, 1'b1, 3, 2, "spurious_resp");
   endtask

   task automatic test_reset_mid();
      bit seen;
      slv_en = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h7; cmd_data = 32'hcafef00d; cmd_sel = 4'hf;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (wb_cyc !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset precondition: got cyc=%b want 1", wb_cyc);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset async: got cyc=%b stb=%b ready=%b rvalid=%b want 0/0/1/0",
                  wb_cyc, wb_stb, cmd_ready, rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL midreset after: response or bus activity appeared after reset");
      end
      do_cmd(1'b0, 32'h4, 32'h0, 4'hf, 2, 1'b1, 0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 18), ($urandom_range(0, 4) != 0), $urandom_range(0, 3), 0,
                "random");
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_backpressure();
      test_timeout();
      test_spurious_ack();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_simple_master.md
Name: wb_simple_master

Overview:
- Synthesizable Wishbone classic (non-pipelined) single-transfer master.
- Converts a valid/ready command port into one Wishbone read or write cycle, and returns the result on a valid/ready response port.
- Lets on-chip logic (sequencers, soft-control FSMs) drive generated register slaves such as gpio_port without a CPU.
- Includes a bus-timeout watchdog so a non-responding slave cannot hang the requester.

Parameters:
g_addr_width, 32, width of cmd_addr_i and wb_addr_o
g_data_width, 32, data width; must be a multiple of 8; select width is g_data_width/8
g_timeout, 255, maximum cycles waiting for wb_ack_i before aborting with error; 0 disables timeout

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready at rising edge
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  g_addr_width  target address
cmd_data_i  in  g_data_width  write data (ignored for reads)
cmd_sel_i  in  g_data_width/8  byte selects
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready at rising edge
rsp_data_o  out  g_data_width  read data; 0 for writes and errors
rsp_err_o  out  1  1=transfer aborted by timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_addr_o  out  g_addr_width  Wishbone address
wb_data_o  out  g_data_width  Wishbone write data
wb_sel_o  out  g_data_width/8  Wishbone byte selects
wb_data_i  in  g_data_width  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (async assert; state clears immediately):
  - All outputs are 0 except cmd_ready_o=1.
  - State is IDLE; timeout counter is 0.
  - Reset asserted mid-cycle drops wb_cyc_o/wb_stb_o at once, and no response is produced.
- All outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i=1 at an edge: latch we/addr/data/sel onto the wb_* outputs, set wb_cyc_o=wb_stb_o=1, clear the counter, go to BUS.
  - For reads, wb_data_o is still loaded with cmd_data_i; slaves ignore it.
- BUS:
  - cmd_ready_o=0; cyc/stb held high; addr/data/sel/we stable.
  - When wb_ack_i=1 at an edge:
    - cyc/stb go to 0 on that edge.
    - rsp_data_o = wb_data_i for a read, 0 for a write.
    - rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - Else if g_timeout!=0 and counter==g_timeout-1:
    - cyc/stb go to 0.
    - rsp_data_o=0, rsp_err_o=1, rsp_valid_o=1, go to RESP.
  - Else counter increments. The counter is wide enough for g_timeout and never wraps.
  - Ack and timeout on the same edge: ack wins (normal completion).
- RESP:
  - rsp_valid_o held with rsp_data_o/rsp_err_o stable until rsp_ready_i=1 at an edge.
  - On that edge: rsp_valid_o=0, go to IDLE (cmd_ready_o=1 next cycle).
- wb_ack_i in IDLE or RESP (spurious or late ack) is ignored and has no effect on state.
- Latency, slave acking on the first BUS cycle with rsp_ready_i held high:
  - Command accepted at edge N; cyc/stb high after N.
  - rsp_valid_o high after N+1; IDLE again after N+2.
  - Minimum 3 cycles per transfer.
- Timeout: an unresponsive slave yields rsp_err_o after exactly g_timeout cycles of cyc/stb high.

Test Plan:
- Write, gpio_port DUT as slave (acks in 1 cycle): cmd write addr=0 (DDR) data=0xffff0000 sel=0xf -> wb_cyc/stb high exactly 1 cycle with wb_we_o=1, wb_data_o=0xffff0000; rsp_valid_o=1, rsp_err_o=0, rsp_data_o=0.
- Read-back: cmd read addr=0 -> rsp_data_o=0xffff0000, rsp_err_o=0; wb_we_o=0 during the cycle.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles after a read of 0xdeadbeef -> rsp_valid_o and rsp_data_o stay stable, cmd_ready_o stays 0, and a cmd_valid_i pulse is not accepted; release -> IDLE and cmd_ready_o=1.
- Timeout: g_timeout=16, slave never acks -> cyc/stb high exactly 16 cycles, then rsp_err_o=1, rsp_data_o=0; an ack arriving on cycle 16 instead -> normal completion with rsp_err_o=0.
- Spurious ack: pulse wb_ack_i in IDLE and in RESP -> no state change, no extra response.
- Reset mid-transfer: assert rst_n_i=0 while in BUS -> wb_cyc_o/wb_stb_o fall without waiting for a clock edge; after release rsp_valid_o=0 and cmd_ready_o=1; the next command completes normally.
